// File: rtl/wall_spawner.sv
// wall_spawner
//
// Multi-obstacle placer for the snake playfield. A tile-aligned candidate
// scanner (cx, cy) advances every cycle. On request, the current candidate is
// committed into the lowest free slot of a NUM_WALLS wall table. A candidate is
// rejected if it hits the snake head or an existing wall. After MAX_TRIES
// rejections the spawn fails.
//
// Build option:
//   WALL_HEAD_GUARD_EN  defined   : head conflict is a 3x3-tile zone, i.e.
//                                   |dx| <= TILE_SIZE and |dy| <= TILE_SIZE
//                       undefined : head conflict is an exact (x, y) match
//
// Ports:
//   clk          in   system clock
//   btnrst       in   synchronous active-high reset
//   snakehead_x  in   [10:0] snake head X (pixels)
//   snakehead_y  in   [10:0] snake head Y (pixels)
//   spawn_req    in   request one new wall (sampled only in IDLE)
//   clear        in   invalidate all walls, abort any search (highest priority)
//   wall_x       out  [NUM_WALLS*11-1:0] slot i X at bits [11i+10:11i]
//   wall_y       out  [NUM_WALLS*11-1:0] slot i Y, same packing
//   wall_valid   out  [NUM_WALLS-1:0] per-slot valid
//   wall_count   out  number of valid slots
//   full         out  all slots valid (combinational)
//   spawn_ack    out  one-cycle pulse, wall committed
//   spawn_fail   out  one-cycle pulse, table full or tries exhausted
//   collide      out  registered, head sits exactly on a valid wall
module wall_spawner #(
    parameter int NUM_WALLS = 4,
    parameter int TILE_SIZE = 32,
    parameter int MIN_X     = 16,
    parameter int MAX_X     = 1392,
    parameter int MIN_Y     = 16,
    parameter int MAX_Y     = 848,
    parameter int INC_X     = 64,
    parameter int INC_Y     = 32,
    parameter int RESET_Y   = 144,
    parameter int MAX_TRIES = 64
) (
    input  logic                             clk,
    input  logic                             btnrst,
    input  logic [10:0]                      snakehead_x,
    input  logic [10:0]                      snakehead_y,
    input  logic                             spawn_req,
    input  logic                             clear,
    output logic [NUM_WALLS*11-1:0]          wall_x,
    output logic [NUM_WALLS*11-1:0]          wall_y,
    output logic [NUM_WALLS-1:0]             wall_valid,
    output logic [$clog2(NUM_WALLS+1)-1:0]   wall_count,
    output logic                             full,
    output logic                             spawn_ack,
    output logic                             spawn_fail,
    output logic                             collide
);

    localparam int CW = $clog2(NUM_WALLS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int IW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;

    localparam logic [10:0] X_WRAP   = 11'(MAX_X - INC_X);
    localparam logic [10:0] Y_WRAP   = 11'(MAX_Y - INC_Y);
    localparam logic [10:0] X_START  = 11'(MIN_X);
    localparam logic [10:0] Y_START  = 11'(RESET_Y);
    localparam logic [10:0] X_STEP   = 11'(INC_X);
    localparam logic [10:0] Y_STEP   = 11'(INC_Y);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    // Reject parameter sets that would overflow the 11-bit scanner or place
    // the Y restart point outside the playfield.
    if (MAX_X + INC_X > 2047 || MAX_Y + INC_Y > 2047 || RESET_Y < MIN_Y ||
        TILE_SIZE < 1 || TILE_SIZE > 2047 || NUM_WALLS < 1 || NUM_WALLS > 16 ||
        MAX_TRIES < 1) begin : g_bad_cfg
        $error("wall_spawner: illegal parameter combination");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [10:0]         cx_q, cx_d;
    logic [10:0]         cy_q, cy_d;
    logic [TW-1:0]       tries_q, tries_d;
    logic [10:0]         wx_q [NUM_WALLS];
    logic [10:0]         wy_q [NUM_WALLS];
    logic [NUM_WALLS-1:0] valid_q, valid_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ack_q, ack_d;
    logic                fail_q, fail_d;
    logic                collide_q, collide_d;

    logic                head_hit;
    logic                wall_hit;
    logic                cand_hit;
    logic                last_try;
    logic                commit;
    logic [IW-1:0]       free_idx;
    logic                full_w;

    // Candidate scanner: free-running, independent of the FSM.
    always_comb begin
        cx_d = (cx_q > X_WRAP) ? X_START : cx_q + X_STEP;
        cy_d = (cy_q > Y_WRAP) ? Y_START : cy_q + Y_STEP;
    end

    // Head conflict for the current candidate.
`ifdef WALL_HEAD_GUARD_EN
    logic [10:0] dx, dy;
    always_comb begin
        dx       = (cx_q >= snakehead_x) ? cx_q - snakehead_x : snakehead_x - cx_q;
        dy       = (cy_q >= snakehead_y) ? cy_q - snakehead_y : snakehead_y - cy_q;
        head_hit = (dx <= 11'(TILE_SIZE)) && (dy <= 11'(TILE_SIZE));
    end
`else
    always_comb begin
        head_hit = (cx_q == snakehead_x) && (cy_q == snakehead_y);
    end
`endif

    // Wall conflict, lowest free slot and collide detection.
    always_comb begin
        wall_hit  = 1'b0;
        collide_d = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if (valid_q[i] && wx_q[i] == cx_q && wy_q[i] == cy_q) begin
                wall_hit = 1'b1;
            end
            if (valid_q[i] && wx_q[i] == snakehead_x && wy_q[i] == snakehead_y) begin
                collide_d = 1'b1;
            end
        end
        // Scan downwards so the last assignment wins: lowest invalid index.
        for (int i = NUM_WALLS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign full_w   = &valid_q;
    assign cand_hit = head_hit | wall_hit;
    assign last_try = (tries_q == LAST_TRY);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (btnrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (spawn_req && !full_w) state_d = SEARCH;
                SEARCH:  if (!cand_hit || last_try) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: commit strobe, pulses and try counter.
    always_comb begin
        tries_d = tries_q;
        commit  = 1'b0;
        ack_d   = 1'b0;
        fail_d  = 1'b0;
        if (!clear) begin
            case (state_q)
                IDLE: begin
                    if (spawn_req) begin
                        if (full_w) begin
                            fail_d = 1'b1;
                        end else begin
                            tries_d = '0;
                        end
                    end
                end
                SEARCH: begin
                    if (!cand_hit) begin
                        commit = 1'b1;
                        ack_d  = 1'b1;
                    end else begin
                        tries_d = tries_q + TW'(1);
                        fail_d  = last_try;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid table update and population count.
    always_comb begin
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (commit) begin
            valid_d[free_idx] = 1'b1;
        end
        count_d = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (btnrst) begin
            cx_q      <= X_START;
            cy_q      <= Y_START;
            tries_q   <= '0;
            valid_q   <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            fail_q    <= 1'b0;
            collide_q <= 1'b0;
            for (int i = 0; i < NUM_WALLS; i++) begin
                wx_q[i] <= '0;
                wy_q[i] <= '0;
            end
        end else begin
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            tries_q   <= tries_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            fail_q    <= fail_d;
            collide_q <= collide_d;
            // Coordinates survive clear; only the valid bits are dropped.
            if (commit) begin
                wx_q[free_idx] <= cx_q;
                wy_q[free_idx] <= cy_q;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WALLS; i++) begin
            wall_x[i*11 +: 11] = wx_q[i];
            wall_y[i*11 +: 11] = wy_q[i];
        end
    end

    assign wall_valid = valid_q;
    assign wall_count = count_q;
    assign full       = full_w;
    assign spawn_ack  = ack_q;
    assign spawn_fail = fail_q;
    assign collide    = collide_q;

endmodule

// File: tb/tb_wall_spawner.sv
// Testbench for wall_spawner (default parameters). The reference model
// computes the candidate at any cycle directly from the cycle index and
// predicts each spawn outcome by walking future candidates against a
// behavioural wall table.
module tb_wall_spawner;

    localparam int NW  = 4;
    localparam int MT  = 64;
    localparam int NX  = 22;      // X values 16, 80, ..., 1360
    localparam int NY  = 23;      // Y values 144, 176, ..., 848
    localparam int PER = NX * NY;

    logic             clk = 1'b0;
    logic             btnrst;
    logic             spawn_req;
    logic             clear;
    logic [10:0]      snakehead_x;
    logic [10:0]      snakehead_y;
    logic [NW*11-1:0] wall_x;
    logic [NW*11-1:0] wall_y;
    logic [NW-1:0]    wall_valid;
    logic [2:0]       wall_count;
    logic             full;
    logic             spawn_ack;
    logic             spawn_fail;
    logic             collide;

    int compared   = 0;
    int mismatched = 0;
    int n          = 0;   // cycles since reset release: candidate index
    int mx [NW];
    int my [NW];
    bit mv [NW];

    always #5 clk = ~clk;

    wall_spawner dut (
        .clk         (clk),
        .btnrst      (btnrst),
        .snakehead_x (snakehead_x),
        .snakehead_y (snakehead_y),
        .spawn_req   (spawn_req),
        .clear       (clear),
        .wall_x      (wall_x),
        .wall_y      (wall_y),
        .wall_valid  (wall_valid),
        .wall_count  (wall_count),
        .full        (full),
        .spawn_ack   (spawn_ack),
        .spawn_fail  (spawn_fail),
        .collide     (collide)
    );

    function automatic int cand_x(input int k);
        return 16 + 64 * (k % NX);
    endfunction

    function automatic int cand_y(input int k);
        return 144 + 32 * (k % NY);
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic bit head_conf(input int x, input int y, input int hx, input int hy);
`ifdef WALL_HEAD_GUARD_EN
        return (absdiff(x, hx) <= 32) && (absdiff(y, hy) <= 32);
`else
        return (x == hx) && (y == hy);
`endif
    endfunction

    function automatic bit wall_conf(input int x, input int y);
        for (int i = 0; i < NW; i++) begin
            if (mv[i] && mx[i] == x && my[i] == y) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < NW; i++) c += int'(mv[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_table(input string tag);
        logic [NW-1:0] v;
        for (int i = 0; i < NW; i++) v[i] = mv[i];
        check({tag, "/valid"}, 64'(wall_valid), 64'(v));
        check({tag, "/count"}, 64'(wall_count), 64'(mcount()));
        check({tag, "/full"},  64'(full),       64'(mcount() == NW));
        for (int i = 0; i < NW; i++) begin
            check({tag, "/slot_x"}, 64'(wall_x[i*11 +: 11]), 64'(mx[i]));
            check({tag, "/slot_y"}, 64'(wall_y[i*11 +: 11]), 64'(my[i]));
        end
    endtask

    task automatic step();
        bit r;
        r = btnrst;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else   n++;
    endtask

    task automatic set_head(input int x, input int y);
        snakehead_x = 11'(x);
        snakehead_y = 11'(y);
    endtask

    // Issue one request and follow it to its ack or fail pulse.
    // track=1 drives the head onto every candidate during the search.
    task automatic spawn(input string tag, input bit track);
        bit found;
        bit was_full;
        int lat;
        int ci;
        int slot;
        int hx;
        int hy;
        was_full = (mcount() == NW);
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        if (was_full) begin
            check({tag, "/full_fail"}, 64'(spawn_fail), 64'd1);
            check({tag, "/full_ack"},  64'(spawn_ack),  64'd0);
            check_table({tag, "/full"});
            step();
            check({tag, "/fail_pulse"}, 64'(spawn_fail), 64'd0);
            return;
        end
        found = 1'b0;
        lat   = MT;
        ci    = 0;
        for (int k = 0; k < MT; k++) begin
            hx = track ? cand_x(n + k) : int'(snakehead_x);
            hy = track ? cand_y(n + k) : int'(snakehead_y);
            if (!head_conf(cand_x(n + k), cand_y(n + k), hx, hy) &&
                !wall_conf(cand_x(n + k), cand_y(n + k))) begin
                found = 1'b1;
                lat   = k + 1;
                ci    = n + k;
                break;
            end
        end
        for (int s = 1; s <= lat; s++) begin
            if (track) set_head(cand_x(n), cand_y(n));
            check({tag, "/no_ack_yet"},  64'(spawn_ack),  64'd0);
            check({tag, "/no_fail_yet"}, 64'(spawn_fail), 64'd0);
            step();
        end
        check({tag, "/ack"},  64'(spawn_ack),  64'(found));
        check({tag, "/fail"}, 64'(spawn_fail), 64'(!found));
        if (found) begin
            slot = 0;
            for (int i = NW - 1; i >= 0; i--) if (!mv[i]) slot = i;
            mv[slot] = 1'b1;
            mx[slot] = cand_x(ci);
            my[slot] = cand_y(ci);
        end
        check_table(tag);
        step();
        check({tag, "/ack_pulse"},  64'(spawn_ack),  64'd0);
        check({tag, "/fail_pulse"}, 64'(spawn_fail), 64'd0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) mv[i] = 1'b0;
    endtask

    initial begin
        int ws0;
        int w;
        for (int i = 0; i < NW; i++) begin
            mx[i] = 0;
            my[i] = 0;
            mv[i] = 1'b0;
        end
        btnrst    = 1'b1;
        spawn_req = 1'b0;
        clear     = 1'b0;
        set_head(0, 0);
        step();
        step();
        btnrst = 1'b0;

        // Reset state
        check("rst/ack",     64'(spawn_ack),  64'd0);
        check("rst/fail",    64'(spawn_fail), 64'd0);
        check("rst/collide", 64'(collide),    64'd0);
        check_table("rst");

        // Clear path: commit the candidate of the first search cycle
        ws0 = n + 1;
        spawn("basic", 1'b0);
        check("basic/slot0_x", 64'(wall_x[10:0]), 64'(cand_x(ws0)));

        // Same candidate comes round again after PER cycles: wall conflict
        while ((n + 1) % PER != ws0 % PER) step();
        spawn("wallrej", 1'b0);

        // Head on the first search candidate
        set_head(cand_x(n + 1), cand_y(n + 1));
        spawn("headrej", 1'b0);

`ifdef WALL_HEAD_GUARD_EN
        set_head(cand_x(n + 1) + 32, cand_y(n + 1) + 32);
        spawn("guard", 1'b0);
`else
        set_head(cand_x(n + 1) + 32, cand_y(n + 1) + 32);
        spawn("offset", 1'b0);
`endif

        // Table full: immediate fail
        set_head(0, 0);
        check("full/flag", 64'(full), 64'd1);
        spawn("fifth", 1'b0);

        // Collide follows the head one cycle later
        step();
        check("collide/off", 64'(collide), 64'd0);
        set_head(mx[0], my[0]);
        step();
        check("collide/on", 64'(collide), 64'd1);

        // Clear drops every wall
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        check("clear/ack",  64'(spawn_ack),  64'd0);
        check("clear/fail", 64'(spawn_fail), 64'd0);
        check_table("clear");
        step();
        check("clear/collide", 64'(collide), 64'd0);

        // Head tracking the candidate exhausts the tries
        spawn("exhaust", 1'b1);

        // Clear during SEARCH aborts with no pulse
        set_head(0, 0);
        spawn("refill", 1'b0);
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        set_head(cand_x(n), cand_y(n));
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        check_table("abort");
        for (int s = 0; s < 3; s++) begin
            check("abort/ack",  64'(spawn_ack),  64'd0);
            check("abort/fail", 64'(spawn_fail), 64'd0);
            set_head(cand_x(n + 1), cand_y(n + 1));
            step();
        end
        set_head(0, 0);
        spawn("after_abort", 1'b0);

        // clear and spawn_req together: request dropped
        clear     = 1'b1;
        spawn_req = 1'b1;
        step();
        clear     = 1'b0;
        spawn_req = 1'b0;
        model_clear();
        for (int s = 0; s < 3; s++) begin
            check("clrreq/ack",  64'(spawn_ack),  64'd0);
            check("clrreq/fail", 64'(spawn_fail), 64'd0);
            step();
        end
        check_table("clrreq");

        // Randomized requests against the model
        for (int it = 0; it < 30; it++) begin
            w = $urandom_range(0, 5);
            for (int s = 0; s < w; s++) step();
            if (mcount() == NW && $urandom_range(0, 1) == 1) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                model_clear();
                check_table("rnd_clear");
            end
            case ($urandom_range(0, 2))
                0: begin
                    w = n + 1 + $urandom_range(0, 2);
                    set_head(cand_x(w), cand_y(w));
                end
                1: set_head($urandom_range(0, 1500), $urandom_range(0, 900));
                default: set_head(0, 0);
            endcase
            spawn("rnd", 1'b0);
            if (mcount() > 0 && $urandom_range(0, 2) == 0) begin
                w = 0;
                for (int i = NW - 1; i >= 0; i--) if (mv[i]) w = i;
                set_head(mx[w], my[w]);
                step();
                check("rnd_collide/on", 64'(collide), 64'd1);
                set_head(2040, 2040);
                step();
                check("rnd_collide/off", 64'(collide), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
